// File: rtl/disparity_sad_engine.sv
// disparity_sad_engine: captures left/right frames, then streams one SAD-window disparity per left pixel.
// Optional macro DISP_COST_OUT_EN adds cost_out carrying the winning window cost.
module disparity_sad_engine #(
  parameter int PIX_W = 8,
  parameter int WIDTH = 46,
  parameter int HEIGHT = 30,
  parameter int MAX_DISP = 16,
  parameter int HALF_BLOCK = 3,
  localparam int DISP_W = $clog2(MAX_DISP),
  localparam int COST_W = PIX_W + $clog2(2*HALF_BLOCK+2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              image_sel,
  output logic [DISP_W-1:0] disp_out,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic              idle
`ifdef DISP_COST_OUT_EN
  , output logic [COST_W-1:0] cost_out
`endif
);
  localparam int NPIX = WIDTH*HEIGHT;
  localparam int A_W = $clog2(NPIX);
  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);
  localparam int K_W = $clog2(2*HALF_BLOCK+2);
  localparam logic [A_W-1:0] A_LAST = A_W'(NPIX-1);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH-1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT-1);
  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, EMIT} state_t;
  state_t state;
  logic [PIX_W-1:0] lmem [NPIX];
  logic [PIX_W-1:0] rmem [NPIX];
  logic [A_W-1:0] waddr, row_base, raddr_l, raddr_r;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [K_W-1:0] k;
  logic [DISP_W-1:0] d, p_d, best_d, win_d;
  logic issuing, p_valid, p_end, p_last, end_d, last, take;
  logic [PIX_W-1:0] rd_l, rd_r, term;
  logic [COST_W-1:0] acc, best_cost, sum;
  int cmin, cmax, dmax;
  always_comb begin
    cmin = (int'(x) > HALF_BLOCK) ? int'(x) - HALF_BLOCK : 0;
    cmax = (int'(x) + HALF_BLOCK > WIDTH - 1) ? WIDTH - 1 : int'(x) + HALF_BLOCK;
    dmax = (cmin > MAX_DISP - 1) ? MAX_DISP - 1 : cmin;
    end_d = int'(k) == cmax - cmin;
    last = end_d && int'(d) == dmax;
    raddr_l = A_W'(int'(row_base) + cmin + int'(k));
    raddr_r = A_W'(int'(row_base) + cmin + int'(k) - int'(d));
    term = rd_l > rd_r ? rd_l - rd_r : rd_r - rd_l;
    sum = acc + COST_W'(term);
    take = p_d == '0 || sum < best_cost;
    win_d = take ? p_d : best_d;
  end
  // Frame stores are never reset; every location is rewritten during LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD && pix_valid && pix_ready && !image_sel) lmem[waddr] <= pix_in;
    if (state == LOAD && pix_valid && pix_ready && image_sel) rmem[waddr] <= pix_in;
    rd_l <= lmem[raddr_l];
    rd_r <= rmem[raddr_r];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pix_ready <= 1'b0;
      image_sel <= 1'b0;
      disp_out <= '0;
      disp_valid <= 1'b0;
      idle <= 1'b1;
      waddr <= '0;
      row_base <= '0;
      x <= '0;
      y <= '0;
      k <= '0;
      d <= '0;
      issuing <= 1'b0;
      p_valid <= 1'b0;
      p_end <= 1'b0;
      p_last <= 1'b0;
      p_d <= '0;
      acc <= '0;
      best_cost <= '0;
      best_d <= '0;
`ifdef DISP_COST_OUT_EN
      cost_out <= '0;
`endif
    end else begin
      // Read data lags the issued address by one cycle, so the term's tags travel with it.
      p_valid <= issuing;
      p_end <= end_d;
      p_last <= last;
      p_d <= d;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          pix_ready <= 1'b1;
          image_sel <= 1'b0;
          waddr <= '0;
          idle <= 1'b0;
        end
        LOAD: if (pix_valid) begin
          waddr <= waddr == A_LAST ? '0 : waddr + A_W'(1);
          if (waddr == A_LAST) image_sel <= 1'b1;
          if (waddr == A_LAST && image_sel) begin
            state <= ACCUM;
            pix_ready <= 1'b0;
            image_sel <= 1'b0;
            x <= '0;
            y <= '0;
            row_base <= '0;
            k <= '0;
            d <= '0;
            issuing <= 1'b1;
          end
        end
        ACCUM: begin
          if (issuing) begin
            k <= end_d ? '0 : k + K_W'(1);
            if (end_d && !last) d <= d + DISP_W'(1);
            if (last) issuing <= 1'b0;
          end
          if (p_valid) begin
            acc <= p_end ? '0 : sum;
            if (p_end && take) begin
              best_cost <= sum;
              best_d <= p_d;
            end
            if (p_last) begin
              state <= EMIT;
              disp_valid <= 1'b1;
              disp_out <= win_d;
`ifdef DISP_COST_OUT_EN
              cost_out <= take ? sum : best_cost;
`endif
            end
          end
        end
        EMIT: if (disp_ready) begin
          disp_valid <= 1'b0;
          if (x == X_LAST && y == Y_LAST) begin
            state <= IDLE;
            idle <= 1'b1;
          end else begin
            state <= ACCUM;
            issuing <= 1'b1;
            k <= '0;
            d <= '0;
            x <= x == X_LAST ? '0 : x + X_W'(1);
            if (x == X_LAST) begin
              y <= y + Y_W'(1);
              row_base <= row_base + A_W'(WIDTH);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
